// File: rtl/mips_pkg.sv
// Shared encodings, FSM state type and defaults for the mips_cpu_bus core.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_EXEC   = 3'd1,
    ST_MEM    = 3'd2,
    ST_WB     = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D, OP_XORI   = 6'h0E, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW   = 6'h23, OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH   = 6'h29, OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  // Pick the addressed lane(s) out of a read word and extend per load opcode.
  function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [1:0] lo,
                                              input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    b = data[{lo, 3'b000} +: 8];
    h = lo[1] ? data[31:16] : data[15:0];
    case (op)
      OP_LB:   load_extend = {{24{b[7]}}, b};
      OP_LBU:  load_extend = {24'h000000, b};
      OP_LH:   load_extend = {{16{h[15]}}, h};
      OP_LHU:  load_extend = {16'h0000, h};
      default: load_extend = data;
    endcase
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 general-purpose register file: two async read ports, one sync write port.
// $0 is never written, so it always reads as zero.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] v0_o
);
  logic [31:0] regs_q [32];

  // Synchronous clear on reset, single write port otherwise.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0000_0000;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];
  assign v0_o      = regs_q[2];

endmodule

// File: rtl/mips_cpu_bus.sv
// Multicycle MIPS-I subset core with one Avalon-MM master: FETCH -> EXEC -> (MEM -> WB) -> FETCH.
// All bus outputs are registered; pc_q/npc_q carry the branch delay slot.
module mips_cpu_bus
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);
  state_e      state_q;
  logic [31:0] pc_q, npc_q, ir_q, mdr_q, address_q, writedata_q;
  logic [3:0]  byteenable_q;
  logic [1:0]  ea_lo_q;
  logic        read_q, write_q, active_q;

  logic [5:0]  op_s, fn_s;
  logic [4:0]  rs_s, rt_s, rd_s, sh_s, alu_wa_s, rf_wa_s;
  logic [31:0] simm_s, zimm_s, rs_val_s, rt_val_s, pc4_s, br_tgt_s, ea_s;
  logic [31:0] alu_res_s, target_s, npc_d, st_data_s, rf_wd_s, fetch_addr_s;
  logic [3:0]  lanes_s;
  logic        alu_we_s, is_load_s, is_store_s, taken_s, rf_we_s, retire_s;

  assign op_s     = ir_q[31:26];
  assign rs_s     = ir_q[25:21];
  assign rt_s     = ir_q[20:16];
  assign rd_s     = ir_q[15:11];
  assign sh_s     = ir_q[10:6];
  assign fn_s     = ir_q[5:0];
  assign simm_s   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zimm_s   = {16'h0000, ir_q[15:0]};
  assign pc4_s    = pc_q + 32'd4;
  assign br_tgt_s = pc4_s + {simm_s[29:0], 2'b00};
  assign ea_s     = rs_val_s + simm_s;

  // Decode and execute: ALU result, register write target, branch resolution.
  always_comb begin
    alu_we_s   = 1'b0;
    alu_wa_s   = rd_s;
    alu_res_s  = 32'h0000_0000;
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    taken_s    = 1'b0;
    target_s   = br_tgt_s;
    case (op_s)
      OP_SPECIAL: begin
        alu_we_s = 1'b1;
        case (fn_s)
          FN_SLL:  alu_res_s = rt_val_s << sh_s;
          FN_SRL:  alu_res_s = rt_val_s >> sh_s;
          FN_SRA:  alu_res_s = $unsigned($signed(rt_val_s) >>> sh_s);
          FN_SLLV: alu_res_s = rt_val_s << rs_val_s[4:0];
          FN_SRLV: alu_res_s = rt_val_s >> rs_val_s[4:0];
          FN_SRAV: alu_res_s = $unsigned($signed(rt_val_s) >>> rs_val_s[4:0]);
          FN_JR:   begin alu_we_s = 1'b0; taken_s = 1'b1; target_s = rs_val_s; end
          FN_JALR: begin taken_s = 1'b1; target_s = rs_val_s; alu_res_s = pc_q + 32'd8; end
          FN_ADDU: alu_res_s = rs_val_s + rt_val_s;
          FN_SUBU: alu_res_s = rs_val_s - rt_val_s;
          FN_AND:  alu_res_s = rs_val_s & rt_val_s;
          FN_OR:   alu_res_s = rs_val_s | rt_val_s;
          FN_XOR:  alu_res_s = rs_val_s ^ rt_val_s;
          FN_NOR:  alu_res_s = ~(rs_val_s | rt_val_s);
          FN_SLT:  alu_res_s = {31'd0, $signed(rs_val_s) < $signed(rt_val_s)};
          FN_SLTU: alu_res_s = {31'd0, rs_val_s < rt_val_s};
          default: alu_we_s = 1'b0;
        endcase
      end
      OP_REGIMM: taken_s = (rt_s == 5'd0) ? rs_val_s[31] : ((rt_s == 5'd1) ? !rs_val_s[31] : 1'b0);
      OP_J:      begin taken_s = 1'b1; target_s = {pc4_s[31:28], ir_q[25:0], 2'b00}; end
      OP_JAL: begin
        taken_s   = 1'b1;
        target_s  = {pc4_s[31:28], ir_q[25:0], 2'b00};
        alu_we_s  = 1'b1;
        alu_wa_s  = 5'd31;
        alu_res_s = pc_q + 32'd8;
      end
      OP_BEQ:   taken_s = (rs_val_s == rt_val_s);
      OP_BNE:   taken_s = (rs_val_s != rt_val_s);
      OP_BLEZ:  taken_s = rs_val_s[31] || (rs_val_s == 32'd0);
      OP_BGTZ:  taken_s = !rs_val_s[31] && (rs_val_s != 32'd0);
      OP_ADDIU: begin alu_we_s = 1'b1; alu_wa_s = rt_s; alu_res_s = rs_val_s + simm_s; end
      OP_SLTI:  begin alu_we_s = 1'b1; alu_wa_s = rt_s; alu_res_s = {31'd0, $signed(rs_val_s) < $signed(simm_s)}; end
      OP_SLTIU: begin alu_we_s = 1'b1; alu_wa_s = rt_s; alu_res_s = {31'd0, rs_val_s < simm_s}; end
      OP_ANDI:  begin alu_we_s = 1'b1; alu_wa_s = rt_s; alu_res_s = rs_val_s & zimm_s; end
      OP_ORI:   begin alu_we_s = 1'b1; alu_wa_s = rt_s; alu_res_s = rs_val_s | zimm_s; end
      OP_XORI:  begin alu_we_s = 1'b1; alu_wa_s = rt_s; alu_res_s = rs_val_s ^ zimm_s; end
      OP_LUI:   begin alu_we_s = 1'b1; alu_wa_s = rt_s; alu_res_s = {ir_q[15:0], 16'h0000}; end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load_s = 1'b1;
      OP_SB, OP_SH, OP_SW:                 is_store_s = 1'b1;
      default:  alu_we_s = 1'b0;
    endcase
  end

  // Byte-lane mask and lane-replicated store data for the current access size.
  always_comb begin
    case (op_s)
      OP_LB, OP_LBU, OP_SB: begin lanes_s = 4'b0001 << ea_s[1:0]; st_data_s = {4{rt_val_s[7:0]}}; end
      OP_LH, OP_LHU, OP_SH: begin lanes_s = ea_s[1] ? 4'b1100 : 4'b0011; st_data_s = {2{rt_val_s[15:0]}}; end
      default:              begin lanes_s = 4'b1111; st_data_s = rt_val_s; end
    endcase
  end

  assign npc_d        = taken_s ? target_s : (npc_q + 32'd4);
  assign retire_s     = ((state_q == ST_EXEC) && !is_load_s && !is_store_s)
                     || ((state_q == ST_MEM) && write_q && !waitrequest)
                     || (state_q == ST_WB);
  // EXEC has not yet advanced pc_q, so it fetches from npc_q; MEM/WB already did.
  assign fetch_addr_s = (state_q == ST_EXEC) ? npc_q : pc_q;

  assign rf_we_s = ((state_q == ST_EXEC) && alu_we_s) || (state_q == ST_WB);
  assign rf_wa_s = (state_q == ST_WB) ? rt_s : alu_wa_s;
  assign rf_wd_s = (state_q == ST_WB) ? load_extend(op_s, ea_lo_q, mdr_q) : alu_res_s;

  mips_regfile u_regfile (
    .clk_i     (clk),
    .reset_i   (reset),
    .raddr_a_i (rs_s),
    .rdata_a_o (rs_val_s),
    .raddr_b_i (rt_s),
    .rdata_b_o (rt_val_s),
    .we_i      (rf_we_s),
    .waddr_i   (rf_wa_s),
    .wdata_i   (rf_wd_s),
    .v0_o      (register_v0)
  );

  // Control FSM with registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_VECTOR;
      npc_q        <= RESET_VECTOR + 32'd4;
      ir_q         <= 32'h0000_0000;
      mdr_q        <= 32'h0000_0000;
      ea_lo_q      <= 2'b00;
      address_q    <= RESET_VECTOR;
      writedata_q  <= 32'h0000_0000;
      byteenable_q <= 4'b0000;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!read_q) begin
            read_q       <= 1'b1;
            active_q     <= 1'b1;
            address_q    <= pc_q;
            byteenable_q <= 4'b1111;
          end else if (!waitrequest) begin
            ir_q    <= readdata;
            read_q  <= 1'b0;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          pc_q  <= npc_q;
          npc_q <= npc_d;
          if (is_load_s || is_store_s) begin
            state_q      <= ST_MEM;
            read_q       <= is_load_s;
            write_q      <= is_store_s;
            address_q    <= {ea_s[31:2], 2'b00};
            ea_lo_q      <= ea_s[1:0];
            writedata_q  <= st_data_s;
            byteenable_q <= lanes_s;
          end
        end
        ST_MEM: begin
          if (!waitrequest) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            mdr_q   <= readdata;
            if (read_q) state_q <= ST_WB;
          end
        end
        ST_WB: ;
        ST_HALTED: begin
          read_q   <= 1'b0;
          write_q  <= 1'b0;
          active_q <= 1'b0;
        end
        default: begin
          state_q  <= ST_HALTED;
          read_q   <= 1'b0;
          write_q  <= 1'b0;
          active_q <= 1'b0;
        end
      endcase
      if (retire_s) begin
        if (fetch_addr_s == 32'h0000_0000) begin
          state_q  <= ST_HALTED;
          active_q <= 1'b0;
          read_q   <= 1'b0;
        end else begin
          state_q      <= ST_FETCH;
          read_q       <= 1'b1;
          address_q    <= fetch_addr_s;
          byteenable_q <= 4'b1111;
        end
      end
    end
  end

  assign active     = active_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Directed bench for mips_cpu_bus: small Avalon slave with instruction ROM at the reset
// vector and a 64-word data RAM at address 0, plus a bus monitor.
module tb_mips_cpu_bus;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active, write, read, waitrequest = 1'b0;
  logic [31:0] register_v0, address, writedata, readdata = 32'hDEAD_BEEF;
  logic [3:0]  byteenable;

  mips_cpu_bus dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .address(address), .write(write), .read(read), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [64];
  logic [31:0] dinit [64];
  logic [31:0] dmem [64];
  int          dstall = 0;
  int          init_tok = 0, seen_tok = 0, stall_cnt = 0;
  int          n_checks = 0, n_fail = 0;

  // Slave: commit writes on the edge, then answer the new request just after it.
  always @(posedge clk) begin
    logic [31:0] off;
    if (write && !waitrequest)
      for (int n = 0; n < 4; n++)
        if (byteenable[n]) dmem[address[7:2]][8*n +: 8] = writedata[8*n +: 8];
    if (init_tok != seen_tok) begin
      for (int i = 0; i < 64; i++) dmem[i] = dinit[i];
      seen_tok = init_tok;
    end
    #1;
    if (read || write) begin
      if (stall_cnt < ((address[31:28] == 4'hB) ? 0 : dstall)) begin
        waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        waitrequest = 1'b0;
        stall_cnt = 0;
      end
      off = address - 32'hBFC0_0000;
      if (waitrequest || !read) readdata = 32'hDEAD_BEEF;
      else readdata = (address[31:28] == 4'hB) ? imem[off[7:2]] : dmem[address[7:2]];
    end else begin
      waitrequest = 1'b0;
      stall_cnt = 0;
      readdata = 32'hDEAD_BEEF;
    end
  end

  int          rw_both = 0, req_cycles = 0, wr_cycles = 0, wr_xfers = 0, wr_unstable = 0;
  logic        wr_open = 1'b0;
  logic [31:0] wa0, wd0;
  logic [3:0]  wb0;
  logic [31:0] wlog_addr [$], wlog_data [$], flog [$];
  logic [3:0]  wlog_be [$];

  // Monitor: protocol counters, write-hold stability, completed write and fetch logs.
  always @(negedge clk) begin
    if (read && write) rw_both++;
    if (read || write) req_cycles++;
    if (write) begin
      wr_cycles++;
      if (!wr_open) begin
        wr_open = 1'b1; wa0 = address; wd0 = writedata; wb0 = byteenable;
      end else if (address != wa0 || writedata != wd0 || byteenable != wb0) begin
        wr_unstable++;
      end
      if (!waitrequest) begin
        wr_xfers++;
        wlog_addr.push_back(address);
        wlog_data.push_back(writedata);
        wlog_be.push_back(byteenable);
        wr_open = 1'b0;
      end
    end
    if (read && !waitrequest && address[31:28] == 4'hB) flog.push_back(address);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0000;
  endtask

  // Leaves the bench at the negedge where reset has just been released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_to_halt(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (active && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'd0, active}, 32'd0);
  endtask

  localparam logic [31:0] JR0 = 32'h0000_0008;

  initial begin
    int fb, wb, wc, wx, wu, rq, n;
    for (int i = 0; i < 64; i++) dinit[i] = 32'h0000_0000;

    // Reset state, then first fetch out of reset.
    clear_imem();
    imem[0] = enc_i(6'h09, 5'd0, 5'd2, 16'd5);
    imem[1] = JR0;
    fb = flog.size();
    init_tok++;
    do_reset();
    check_eq("rst_read",   {31'd0, read},   32'd0);
    check_eq("rst_write",  {31'd0, write},  32'd0);
    check_eq("rst_active", {31'd0, active}, 32'd0);
    check_eq("rst_v0",     register_v0,     32'd0);
    @(negedge clk);
    check_eq("f1_addr",   address,           32'hBFC0_0000);
    check_eq("f1_read",   {31'd0, read},     32'd1);
    check_eq("f1_be",     {28'd0, byteenable}, 32'h0000_000F);
    check_eq("f1_write",  {31'd0, write},    32'd0);
    check_eq("f1_active", {31'd0, active},   32'd1);

    // ADDIU $2,$0,5 ; JR $0 ; NOP -> halt after the NOP.
    run_to_halt("t2_halt");
    check_eq("t2_v0", register_v0, 32'd5);
    check_eq("t2_fetches", flog.size() - fb, 32'd3);
    rq = req_cycles;
    repeat (10) @(negedge clk);
    check_eq("t2_idle_reqs", req_cycles - rq, 32'd0);

    // SW of 0x12345678 to 0x10 with three wait cycles.
    clear_imem();
    imem[0] = enc_i(6'h0F, 5'd0, 5'd3, 16'h1234);
    imem[1] = enc_i(6'h0D, 5'd3, 5'd3, 16'h5678);
    imem[2] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0010);
    imem[3] = JR0;
    dstall = 3;
    wb = wlog_addr.size(); wc = wr_cycles; wx = wr_xfers; wu = wr_unstable;
    init_tok++;
    do_reset();
    run_to_halt("t3_halt");
    check_eq("t3_wr_cycles", wr_cycles - wc, 32'd4);
    check_eq("t3_xfers", wr_xfers - wx, 32'd1);
    check_eq("t3_unstable", wr_unstable - wu, 32'd0);
    check_eq("t3_addr", wlog_addr[wb], 32'h0000_0010);
    check_eq("t3_data", wlog_data[wb], 32'h1234_5678);
    check_eq("t3_be", {28'd0, wlog_be[wb]}, 32'h0000_000F);
    check_eq("t3_mem", dmem[4], 32'h1234_5678);

    // LB / LBU of 0x80, SB into lane 2.
    clear_imem();
    imem[0] = enc_i(6'h20, 5'd0, 5'd2, 16'h0009);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd2, 16'h0020);
    imem[2] = enc_i(6'h24, 5'd0, 5'd2, 16'h0009);
    imem[3] = enc_i(6'h28, 5'd0, 5'd2, 16'h0012);
    imem[4] = JR0;
    dinit[2] = 32'h0000_8000;
    dinit[4] = 32'h1122_3344;
    dstall = 1;
    wb = wlog_addr.size();
    init_tok++;
    do_reset();
    run_to_halt("t4_halt");
    check_eq("t4_lb_store", dmem[8], 32'hFFFF_FF80);
    check_eq("t4_lbu_v0", register_v0, 32'h0000_0080);
    check_eq("t4_sb_addr", wlog_addr[wb+1], 32'h0000_0010);
    check_eq("t4_sb_be", {28'd0, wlog_be[wb+1]}, 32'h0000_0004);
    check_eq("t4_sb_data", wlog_data[wb+1], 32'h8080_8080);
    check_eq("t4_sb_mem", dmem[4], 32'h1180_3344);

    // BEQ taken with an increment in the delay slot.
    clear_imem();
    imem[0] = enc_i(6'h09, 5'd0, 5'd2, 16'd10);
    imem[1] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
    imem[2] = enc_i(6'h09, 5'd2, 5'd2, 16'd1);
    imem[3] = enc_i(6'h09, 5'd2, 5'd2, 16'd100);
    imem[4] = enc_i(6'h09, 5'd2, 5'd2, 16'd16);
    imem[5] = JR0;
    dstall = 0;
    fb = flog.size();
    init_tok++;
    do_reset();
    run_to_halt("t5_halt");
    check_eq("t5_v0", register_v0, 32'd27);
    check_eq("t5_fetches", flog.size() - fb, 32'd6);
    check_eq("t5_slot_addr", flog[fb+2], 32'hBFC0_0008);
    check_eq("t5_target_addr", flog[fb+3], 32'hBFC0_0010);

    // Arithmetic shift of a negative value and SLTI with a sign-extended immediate.
    clear_imem();
    imem[0] = enc_i(6'h09, 5'd0, 5'd3, 16'hFFF8);
    imem[1] = enc_r(5'd0, 5'd3, 5'd4, 5'd1, 6'h03);
    imem[2] = enc_i(6'h0A, 5'd4, 5'd5, 16'hFFFD);
    imem[3] = enc_r(5'd4, 5'd5, 5'd2, 5'd0, 6'h21);
    imem[4] = JR0;
    init_tok++;
    do_reset();
    run_to_halt("t6_halt");
    check_eq("t6_sra_slti", register_v0, 32'hFFFF_FFFD);

    // Reset asserted while a load is stalled.
    clear_imem();
    imem[0] = enc_i(6'h09, 5'd0, 5'd2, 16'd7);
    imem[1] = enc_i(6'h23, 5'd0, 5'd2, 16'h0000);
    imem[2] = JR0;
    dinit[0] = 32'hCAFE_0001;
    dstall = 20;
    init_tok++;
    do_reset();
    n = 0;
    while (!(read && address == 32'h0000_0000) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("t7_load_seen", {31'd0, read && address == 32'h0000_0000}, 32'd1);
    repeat (2) @(negedge clk);
    check_eq("t7_v0_before", register_v0, 32'd7);
    check_eq("t7_stalled", {31'd0, waitrequest}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t7_read_drop", {31'd0, read}, 32'd0);
    check_eq("t7_active_drop", {31'd0, active}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t7_refetch_addr", address, 32'hBFC0_0000);
    check_eq("t7_refetch_read", {31'd0, read}, 32'd1);
    check_eq("t7_v0_cleared", register_v0, 32'd0);
    dstall = 0;

    check_eq("no_read_and_write", rw_both, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
